// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one 8-bit repeated-subtraction
// divider between N_REQ requesters. It grants one request at a time, feeds the
// divider its two-cycle dividend/divisor load, waits for done, and returns the
// quotient on an id-tagged response channel.
// Optional build macro: DIV_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts with resp_err=1, resp_q=0 after TIMEOUT_CYCLES cycles without done.
module div_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 300,
    localparam int IDW           = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_dividend,
    input  logic [8*N_REQ-1:0] req_divisor,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [7:0]         resp_q,
    output logic               resp_err,
    output logic               div_start,
    output logic [7:0]         div_data,
    input  logic [7:0]         div_q,
    input  logic               div_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]     state;
    logic [IDW-1:0] last;
    logic [7:0]     divisor_q;

    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [7:0]     sel_dividend;
    logic [7:0]     sel_divisor;
    int             scan_idx;

    // Round-robin search: first valid requester starting just after the last grant.
    always_comb begin
        grant_found  = 1'b0;
        grant_id     = '0;
        sel_dividend = '0;
        sel_divisor  = '0;
        scan_idx     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            scan_idx = (int'(last) + i) % N_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found  = 1'b1;
                grant_id     = scan_idx[IDW-1:0];
                sel_dividend = req_dividend[8*scan_idx +: 8];
                sel_divisor  = req_divisor[8*scan_idx +: 8];
            end
        end
    end

    // One-hot grant, only while idle; held off during reset so every output reads 0.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == S_IDLE) && grant_found)
            req_ready[grant_id] = 1'b1;
    end

    assign resp_valid = (state == S_RESP);

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int WDW = ($clog2(TIMEOUT_CYCLES + 1) > 9) ? $clog2(TIMEOUT_CYCLES + 1) : 9;
    logic [WDW-1:0] wdog;

    // Watchdog counts WAIT cycles; cleared on the way into WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wdog <= '0;
        else if (state == S_LOAD_B)
            wdog <= '0;
        else if (state == S_WAIT)
            wdog <= wdog + 1'b1;
    end
`else
    // Without the watchdog the limit parameter has no meaning.
    if (TIMEOUT_CYCLES < 0) begin : g_no_watchdog
    end
`endif

    // Main sequencer: grant, two-cycle divider load, wait for done, hold response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            last      <= IDW'(N_REQ - 1);
            divisor_q <= '0;
            resp_id   <= '0;
            resp_q    <= '0;
            resp_err  <= 1'b0;
            div_start <= 1'b0;
            div_data  <= '0;
        end else begin
            div_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        last      <= grant_id;
                        resp_id   <= grant_id;
                        divisor_q <= sel_divisor;
                        if (sel_divisor == 8'd0) begin
                            // Divide-by-zero never touches the divider.
                            resp_q   <= 8'hFF;
                            resp_err <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            div_start <= 1'b1;
                            div_data  <= sel_dividend;
                            state     <= S_LOAD_A;
                        end
                    end
                end
                S_LOAD_A: begin
                    div_data <= divisor_q;
                    state    <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_done) begin
                        resp_q   <= div_q;
                        resp_err <= 1'b0;
                        state    <= S_RESP;
                    end
`ifdef DIV_ARB_TIMEOUT_EN
                    else if (wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
                        resp_q   <= 8'h00;
                        resp_err <= 1'b1;
                        state    <= S_RESP;
                    end
`endif
                end
                S_RESP: begin
                    if (resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
